// File: rtl/anubis_pkg.sv
// Shared ANUBIS geometry and the tau byte permutation used by both tau stages.
// Pure declarations: no logic, no latency.
package anubis_pkg;

  localparam int ANUBIS_STATE_BYTES = 16;
  localparam int ANUBIS_DIM         = 4;
  localparam int ANUBIS_IDX_W       = 4;

  localparam logic [ANUBIS_IDX_W-1:0] ANUBIS_LAST_IDX = 4'd15;

  // Output byte 4r+c is taken from input byte 4c+r.
  function automatic logic [ANUBIS_IDX_W-1:0] anubis_tau_idx(input logic [ANUBIS_IDX_W-1:0] j);
    return {j[1:0], j[3:2]};
  endfunction

endpackage

// File: rtl/anubis_tau_bank.sv
// One 16x8 state bank: synchronous write, combinational read.
// Contents clear on asynchronous reset only; no flow control of its own.
module anubis_tau_bank
  import anubis_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    we,
  input  logic [ANUBIS_IDX_W-1:0] waddr,
  input  logic [7:0]              wdata,
  input  logic [ANUBIS_IDX_W-1:0] raddr,
  output logic [7:0]              rdata
);

  logic [7:0] mem [ANUBIS_STATE_BYTES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ANUBIS_STATE_BYTES; i++) mem[i] <= 8'h00;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/anubis_tau_stream.sv
// Byte-serial tau transposition with ping-pong banks; output starts the cycle after the 16th byte lands.
// Sustains one byte/clock each side; in_ready drops only when both banks hold undrained blocks.
module anubis_tau_stream
  import anubis_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  logic                    wr_bank;
  logic                    rd_bank;
  logic [ANUBIS_IDX_W-1:0] wr_idx;
  logic [ANUBIS_IDX_W-1:0] rd_idx;
  logic [1:0]              full;
  logic [1:0]              full_nxt;

  logic                    wr_fire;
  logic                    rd_fire;
  logic                    wr_done;
  logic                    rd_done;
  logic [ANUBIS_IDX_W-1:0] rd_addr;
  logic [7:0]              bank_rdata [2];

  assign in_ready  = ~full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_last  = out_valid & (rd_idx == ANUBIS_LAST_IDX);
  assign out_data  = bank_rdata[rd_bank];

  assign wr_fire = in_valid & in_ready;
  assign rd_fire = out_valid & out_ready;
  assign wr_done = wr_fire & (wr_idx == ANUBIS_LAST_IDX);
  assign rd_done = rd_fire & (rd_idx == ANUBIS_LAST_IDX);
  assign rd_addr = anubis_tau_idx(rd_idx);

  // A filling bank is never full and a draining bank always is, so the
  // set and clear below can never land on the same bit.
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      full    <= 2'b00;
    end else if (clr) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      full    <= 2'b00;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wr_idx <= wr_idx + 4'd1;
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if (rd_fire) begin
        rd_idx <= rd_idx + 4'd1;
        if (rd_done) rd_bank <= ~rd_bank;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    anubis_tau_bank u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (wr_fire & ~clr & (wr_bank == 1'(b))),
      .waddr   (wr_idx),
      .wdata   (in_data),
      .raddr   (rd_addr),
      .rdata   (bank_rdata[b])
    );
  end

  a_no_bank_collision: assert property (@(posedge clk) disable iff (!reset_n)
    !(wr_fire && out_valid && (wr_bank == rd_bank)));

endmodule

// File: tb/tb_anubis_tau_stream.sv
// Randomized scoreboard bench for anubis_tau_stream against a 4x4 matrix-transpose model.
module tb_anubis_tau_stream;
  import anubis_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;

  int checks = 0;
  int passed = 0;
  int or_mode = 0;
  int out_cnt = 0;
  int in_stall = 0;

  logic [7:0] in_buf[$];
  logic [8:0] exp_q[$];
  logic       stall_prev = 1'b0;
  logic [9:0] stall_val = '0;

  localparam int LIMIT = 4000;

  anubis_tau_stream dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: a completed block is a 4x4 byte matrix; output is its transpose read row-major.
  function automatic void model_accept(input logic [7:0] b);
    in_buf.push_back(b);
    if (in_buf.size() == ANUBIS_STATE_BYTES) begin
      for (int j = 0; j < ANUBIS_STATE_BYTES; j++) begin
        int r = j / ANUBIS_DIM;
        int c = j % ANUBIS_DIM;
        exp_q.push_back({(j == ANUBIS_STATE_BYTES - 1), in_buf[ANUBIS_DIM * c + r]});
      end
      in_buf.delete();
    end
  endfunction

  always @(negedge clk) begin
    if (reset_n && clr) begin
      in_buf.delete();
      exp_q.delete();
    end else if (reset_n) begin
      if (in_valid && in_ready) model_accept(in_data);
      if (in_valid && !in_ready) in_stall++;
    end
  end

  always @(negedge clk) begin
    if (reset_n && !clr) begin
      if (stall_prev) chk("hold_stable", {22'd0, out_valid, out_last, out_data}, {22'd0, stall_val});
      stall_prev = out_valid && !out_ready;
      stall_val  = {out_valid, out_last, out_data};
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out: got %0h expected no output", out_data);
        end else begin
          chk("out_byte", {23'd0, out_last, out_data}, {23'd0, exp_q.pop_front()});
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  // Called and returning at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int idle_pct);
    int  t = 0;
    logic done = 1'b0;
    while (int'($urandom_range(99)) < idle_pct) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else begin
        t++;
        if (t >= LIMIT) begin
          checks++;
          $display("FAIL in_timeout: got no acceptance of %0h expected acceptance", b);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0) && (t < LIMIT)) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int stall0;
    int t;

    // Reset values
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    or_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single block 0x00..0x0F and first-output latency
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("pre_last_valid", out_valid, 0);
      send_byte(8'(i), 0);
    end
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 8'h00);
    drain("drain_single");

    // Four back-to-back blocks, no bubbles either side
    stall0 = in_stall;
    base = out_cnt;
    for (int i = 0; i < 64; i++) send_byte(8'(i), 0);
    repeat (16) @(posedge clk);
    #1;
    chk("b2b_out_count", out_cnt - base, 64);
    chk("b2b_in_stall", in_stall - stall0, 0);
    drain("drain_b2b");

    // Backpressure: both banks fill, then release
    or_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) send_byte(8'(8'h40 + i), 0);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    in_valid = 1'b1;
    in_data  = 8'h60;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_still_blocked", in_ready, 0);
    in_valid = 1'b0;
    or_mode = 1;
    for (int i = 32; i < 48; i++) send_byte(8'(8'h40 + i), 0);
    drain("drain_bp");

    // Random valid/ready over 200 blocks
    or_mode = 2;
    for (int i = 0; i < 200 * 16; i++) send_byte(8'($urandom_range(255)), 50);
    or_mode = 1;
    drain("drain_random");

    // Abort a partial block with clr
    base = out_cnt;
    for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(255)), 0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_in_ready", in_ready, 1);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), 0);
    drain("drain_clr");
    chk("clr_out_count", out_cnt - base, 16);

    // Asynchronous reset mid-drain at rd_idx = 5
    base = out_cnt;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(255)), 0);
    t = 0;
    while ((out_cnt - base < 5) && (t < 100)) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("rst_point", out_cnt - base, 5);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    in_buf.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    base = out_cnt;
    for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i), 0);
    drain("drain_after_rst");
    chk("after_rst_count", out_cnt - base, 16);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
